decoder_scan_seq: RTL and testbench

- Parametrised, registered binary-to-one-hot decoder: SEL_W-bit index in, 2**SEL_W-bit one-hot out.
- Adds a command handshake, up/down stepping with wrap, and a timed auto-scan mode with programmable dwell.
- Drives select lines (row/digit/channel enables) from control logic that issues commands rather than holding a static binary code.

---
 rtl/decoder_pkg.sv | 17 +
 rtl/onehot_dec.sv | 15 +
 rtl/decoder_scan_seq.sv | 140 ++++++++++++++
 tb/tb_decoder_scan_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared encodings for the command-driven decoder: command opcodes and FSM states.
package decoder_pkg;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'b00,
    OP_STEP_UP = 2'b01,
    OP_STEP_DN = 2'b10,
    OP_SCAN    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Generic N-to-2**N combinational one-hot decoder.
module onehot_dec #(
  parameter  int SEL_W = 3,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] idx_i,
  output logic [OUT_W-1:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan_seq.sv
// Registered binary-to-one-hot decoder with a command handshake, up/down stepping
// with wrap, and a timed auto-scan mode with programmable dwell.
module decoder_scan_seq
  import decoder_pkg::*;
#(
  parameter  int SEL_W   = 3,
  parameter  int DWELL_W = 8,
  parameter  bit ACT_LOW = 1'b0,
  localparam int OUT_W   = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [SEL_W-1:0]   cmd_sel,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               scan_stop,
  output logic [OUT_W-1:0]   out,
  output logic [SEL_W-1:0]   out_idx,
  output logic               out_valid,
  output logic               scan_active,
  output logic               wrap_pulse,
  output logic [1:0]         dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // cmd_ready depends on the registered state only, so the requester may hold
  // cmd_valid across a scan and the command transfers once the block is back in HOLD.

  localparam logic [SEL_W-1:0] IDX_MAX = '1;
  localparam logic [SEL_W-1:0] IDX_MIN = '0;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]   onehot_q, onehot_d;
  logic [OUT_W-1:0]   dec_next;
  logic               accept;
  op_e                op;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_q != SCAN);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          valid_d = 1'b1;
          state_d = HOLD;
          unique case (op)
            OP_LOAD: idx_d = cmd_sel;
            OP_STEP_UP: begin
              // From IDLE there is no previous index, so stepping seeds an end value.
              if (state_q == IDLE) begin
                idx_d = IDX_MIN;
              end else begin
                idx_d  = idx_q + 1'b1;
                wrap_d = (idx_q == IDX_MAX);
              end
            end
            OP_STEP_DN: begin
              if (state_q == IDLE) begin
                idx_d = IDX_MAX;
              end else begin
                idx_d  = idx_q - 1'b1;
                wrap_d = (idx_q == IDX_MIN);
              end
            end
            OP_SCAN: begin
              idx_d   = cmd_sel;
              dwell_d = cmd_dwell;
              cnt_d   = cmd_dwell;
              state_d = SCAN;
            end
            default: ;
          endcase
        end
      end
      SCAN: begin
        // A stop wins over a step due on the same edge.
        if (scan_stop) begin
          state_d = HOLD;
        end else if (cnt_q == '0) begin
          idx_d  = idx_q + 1'b1;
          wrap_d = (idx_q == IDX_MAX);
          cnt_d  = dwell_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .idx_i    (idx_d),
    .onehot_o (dec_next)
  );

  assign onehot_d = valid_d ? dec_next : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
    end
  end

  assign out         = ACT_LOW ? ~onehot_q : onehot_q;
  assign out_idx     = idx_q;
  assign out_valid   = valid_q;
  assign scan_active = (state_q == SCAN);
  assign wrap_pulse  = wrap_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq: a vector table on the default build plus a short
// hand sequence on a 4-bit, active-low build.
module tb_decoder_scan_seq;

  localparam logic [1:0] LD = 2'b00, UP = 2'b01, DN = 2'b10, SC = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0, S_HOLD = 2'd1, S_SCAN = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: SEL_W=3, ACT_LOW=0 ----------------
  logic       rst, cmd_valid, scan_stop;
  logic [1:0] cmd_op;
  logic [2:0] cmd_sel;
  logic [7:0] cmd_dwell;
  logic       cmd_ready, out_valid, scan_active, wrap_pulse;
  logic [7:0] out;
  logic [2:0] out_idx;
  logic [1:0] dbg_state;

  decoder_scan_seq #(.SEL_W(3), .DWELL_W(8), .ACT_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_dwell(cmd_dwell), .scan_stop(scan_stop),
    .out(out), .out_idx(out_idx), .out_valid(out_valid), .scan_active(scan_active),
    .wrap_pulse(wrap_pulse), .dbg_state(dbg_state)
  );

  // ---------------- DUT B: SEL_W=4, ACT_LOW=1 ----------------
  logic        b_rst, b_cmd_valid, b_scan_stop;
  logic [1:0]  b_cmd_op;
  logic [3:0]  b_cmd_sel;
  logic [7:0]  b_cmd_dwell;
  logic        b_cmd_ready, b_out_valid, b_scan_active, b_wrap_pulse;
  logic [15:0] b_out;
  logic [3:0]  b_out_idx;
  logic [1:0]  b_dbg_state;

  decoder_scan_seq #(.SEL_W(4), .DWELL_W(8), .ACT_LOW(1'b1)) dut_b (
    .clk(clk), .rst(b_rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_op(b_cmd_op), .cmd_sel(b_cmd_sel), .cmd_dwell(b_cmd_dwell), .scan_stop(b_scan_stop),
    .out(b_out), .out_idx(b_out_idx), .out_valid(b_out_valid), .scan_active(b_scan_active),
    .wrap_pulse(b_wrap_pulse), .dbg_state(b_dbg_state)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] op;
    logic [2:0] sel;
    logic [7:0] dwell;
    logic       stop;
    logic [2:0] e_idx;
    logic       e_valid;
    logic [1:0] e_state;
    logic       e_wrap;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] o,
                              input logic [2:0] s, input logic [7:0] d, input logic st,
                              input logic [2:0] ei, input logic ev, input logic [1:0] es,
                              input logic ew);
    vec_t t;
    t.rst = r; t.vld = v; t.op = o; t.sel = s; t.dwell = d; t.stop = st;
    t.e_idx = ei; t.e_valid = ev; t.e_state = es; t.e_wrap = ew;
    return t;
  endfunction

  // ---------------- scoreboard ----------------
  // A: {out[7:0], idx[2:0], valid, ready, scan_active, wrap, state[1:0]}
  logic [16:0] exp_q[$];
  // B: {out[15:0], idx[3:0], valid, wrap}
  logic [21:0] exp_b_q[$];
  int total = 0;
  int bad   = 0;

  task automatic b_step(input logic r, input logic v, input logic [1:0] o, input logic [3:0] s,
                        input logic [15:0] e_out, input logic [3:0] e_idx, input logic e_valid,
                        input logic e_wrap, input string name);
    logic [21:0] want, got;
    @(negedge clk);
    b_rst = r; b_cmd_valid = v; b_cmd_op = o; b_cmd_sel = s;
    exp_b_q.push_back({e_out, e_idx, e_valid, e_wrap});
    @(posedge clk); #1;
    got  = {b_out, b_out_idx, b_out_valid, b_wrap_pulse};
    want = exp_b_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got out=%h idx=%0d valid=%b wrap=%b, want out=%h idx=%0d valid=%b wrap=%b",
               name, got[21:6], got[5:2], got[1], got[0], want[21:6], want[5:2], want[1], want[0]);
    end
  endtask

  initial begin
    logic [7:0]  e_out;
    logic [16:0] want, got;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = LD; cmd_sel = '0; cmd_dwell = '0; scan_stop = 1'b0;
    b_rst = 1'b1; b_cmd_valid = 1'b0; b_cmd_op = LD; b_cmd_sel = '0; b_cmd_dwell = '0; b_scan_stop = 1'b0;

    //              rst vld op  sel dwl stop  idx val state   wrap
    tbl.push_back(mk(1, 0, LD, 0, 0, 0,   0, 0, S_IDLE, 0));  // 0 reset
    tbl.push_back(mk(1, 0, LD, 0, 0, 0,   0, 0, S_IDLE, 0));
    tbl.push_back(mk(0, 1, LD, 5, 0, 0,   5, 1, S_HOLD, 0));  // 2 LOAD 5
    tbl.push_back(mk(0, 0, LD, 0, 0, 0,   5, 1, S_HOLD, 0));
    tbl.push_back(mk(0, 1, LD, 7, 0, 0,   7, 1, S_HOLD, 0));  // 4 LOAD 7
    tbl.push_back(mk(0, 1, UP, 0, 0, 0,   0, 1, S_HOLD, 1));  // 5 wrap up
    tbl.push_back(mk(0, 0, LD, 0, 0, 0,   0, 1, S_HOLD, 0));
    tbl.push_back(mk(0, 1, DN, 0, 0, 0,   7, 1, S_HOLD, 1));  // 7 wrap down
    tbl.push_back(mk(0, 0, LD, 0, 0, 0,   7, 1, S_HOLD, 0));
    tbl.push_back(mk(0, 1, DN, 3, 0, 0,   6, 1, S_HOLD, 0));
    tbl.push_back(mk(0, 1, UP, 3, 0, 0,   7, 1, S_HOLD, 0));
    tbl.push_back(mk(0, 0, LD, 0, 0, 1,   7, 1, S_HOLD, 0));  // 11 stop outside scan
    tbl.push_back(mk(1, 0, LD, 0, 0, 0,   0, 0, S_IDLE, 0));
    tbl.push_back(mk(0, 1, DN, 2, 0, 0,   7, 1, S_HOLD, 0));  // 13 STEP_DN from IDLE
    tbl.push_back(mk(1, 0, LD, 0, 0, 0,   0, 0, S_IDLE, 0));
    tbl.push_back(mk(0, 1, UP, 5, 0, 0,   0, 1, S_HOLD, 0));  // 15 STEP_UP from IDLE
    tbl.push_back(mk(0, 1, LD, 1, 0, 0,   1, 1, S_HOLD, 0));  // 16 back-to-back loads
    tbl.push_back(mk(0, 1, LD, 2, 0, 0,   2, 1, S_HOLD, 0));
    tbl.push_back(mk(0, 1, LD, 3, 0, 0,   3, 1, S_HOLD, 0));
    tbl.push_back(mk(0, 1, SC, 6, 2, 0,   6, 1, S_SCAN, 0));  // 19 SCAN 6 dwell 2
    tbl.push_back(mk(0, 1, LD, 4, 0, 0,   6, 1, S_SCAN, 0));  // LOAD 4 pending
    tbl.push_back(mk(0, 1, LD, 4, 0, 0,   6, 1, S_SCAN, 0));
    tbl.push_back(mk(0, 1, LD, 4, 0, 0,   7, 1, S_SCAN, 0));
    tbl.push_back(mk(0, 1, LD, 4, 0, 0,   7, 1, S_SCAN, 0));
    tbl.push_back(mk(0, 1, LD, 4, 0, 0,   7, 1, S_SCAN, 0));
    tbl.push_back(mk(0, 1, LD, 4, 0, 0,   0, 1, S_SCAN, 1));  // 25 scan wrap
    tbl.push_back(mk(0, 1, LD, 4, 0, 0,   0, 1, S_SCAN, 0));
    tbl.push_back(mk(0, 1, LD, 4, 0, 0,   0, 1, S_SCAN, 0));
    tbl.push_back(mk(0, 1, LD, 4, 0, 1,   0, 1, S_HOLD, 0));  // 28 stop beats due step
    tbl.push_back(mk(0, 1, LD, 4, 0, 0,   4, 1, S_HOLD, 0));  // 29 pending LOAD lands
    tbl.push_back(mk(0, 1, SC, 7, 0, 0,   7, 1, S_SCAN, 0));  // 30 SCAN 7 dwell 0
    tbl.push_back(mk(0, 0, LD, 0, 0, 0,   0, 1, S_SCAN, 1));
    tbl.push_back(mk(0, 0, LD, 0, 0, 0,   1, 1, S_SCAN, 0));
    tbl.push_back(mk(1, 0, LD, 0, 0, 0,   0, 0, S_IDLE, 0));  // 33 reset mid-scan
    tbl.push_back(mk(0, 1, SC, 3, 1, 0,   3, 1, S_SCAN, 0));  // 34 SCAN 3 dwell 1
    tbl.push_back(mk(0, 0, LD, 0, 0, 0,   3, 1, S_SCAN, 0));
    tbl.push_back(mk(0, 0, LD, 0, 0, 0,   4, 1, S_SCAN, 0));
    tbl.push_back(mk(0, 0, LD, 0, 0, 1,   4, 1, S_HOLD, 0));
    tbl.push_back(mk(0, 1, DN, 0, 0, 0,   3, 1, S_HOLD, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; cmd_valid = tbl[i].vld; cmd_op = tbl[i].op;
      cmd_sel = tbl[i].sel; cmd_dwell = tbl[i].dwell; scan_stop = tbl[i].stop;
      e_out = tbl[i].e_valid ? (8'd1 << tbl[i].e_idx) : 8'd0;
      exp_q.push_back({e_out, tbl[i].e_idx, tbl[i].e_valid, tbl[i].e_state != S_SCAN,
                       tbl[i].e_state == S_SCAN, tbl[i].e_wrap, tbl[i].e_state});
      @(posedge clk); #1;
      got  = {out, out_idx, out_valid, cmd_ready, scan_active, wrap_pulse, dbg_state};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL vec%0d: got out=%b idx=%0d valid=%b ready=%b scan=%b wrap=%b state=%0d, want out=%b idx=%0d valid=%b ready=%b scan=%b wrap=%b state=%0d",
                 i, got[16:9], got[8:6], got[5], got[4], got[3], got[2], got[1:0],
                 want[16:9], want[8:6], want[5], want[4], want[3], want[2], want[1:0]);
      end
    end
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0; scan_stop = 1'b0;

    // Active-low 4-bit build
    b_step(1, 0, LD, 4'd0,  16'hFFFF, 4'd0,  0, 0, "b_reset");
    b_step(0, 1, LD, 4'd9,  16'hFDFF, 4'd9,  1, 0, "b_load9");
    b_step(0, 1, LD, 4'd15, 16'h7FFF, 4'd15, 1, 0, "b_load15");
    b_step(0, 1, UP, 4'd0,  16'hFFFE, 4'd0,  1, 1, "b_wrap_up");
    b_step(1, 0, LD, 4'd0,  16'hFFFF, 4'd0,  0, 0, "b_reset2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
